as2650_wb_mailbox: RTL and testbench

Wishbone classic responder on the Caravel management Wishbone bus (wbs_* port of the user area), giving the management SoC a control and mailbox path into the AS2650 core.
- Holds a CPU-reset control bit and an interrupt-enable bit.
- Provides two byte FIFOs: TX (mgmt→CPU) and RX (CPU→mgmt).
- CPU side is a plain valid/ready byte interface.
- Sits inside the user wrapper between the wbs_* pins and wrapped_as2650.

---
 rtl/as2650_mbox_pkg.sv | 33 +++
 rtl/mbox_fifo.sv | 65 ++++++
 rtl/as2650_wb_mailbox.sv | 177 +++++++++++++++++
 tb/tb_as2650_wb_mailbox.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/as2650_mbox_pkg.sv
// Shared register offsets, bit positions and helpers for the AS2650 Wishbone mailbox.
// Used by as2650_wb_mailbox and its testbench.
package as2650_mbox_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_RX_IRQ_EN = 1;
  localparam int CTRL_TX_IRQ_EN = 2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_TX_COUNT = 8;
  localparam int ST_RX_COUNT = 16;

  // RXDATA word: bit8 flags a valid byte; an empty FIFO reads as all zeros.
  function automatic logic [31:0] rxdata_word(input logic empty, input logic [7:0] head);
    logic [31:0] word;
    word = '0;
    if (!empty) begin
      word[8]   = 1'b1;
      word[7:0] = head;
    end
    return word;
  endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module mbox_fifo
  import as2650_mbox_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_COUNT);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/as2650_wb_mailbox.sv
// Wishbone classic mailbox between the Caravel management SoC and the AS2650 core.
// Optional macro AS2650_MBOX_TXIRQ_EN adds CTRL bit2 (tx_irq_en) and a TX-empty interrupt term.
module as2650_wb_mailbox
  import as2650_mbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cpu_rst_n_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        irq_o
);

`ifdef AS2650_MBOX_TXIRQ_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 2;
`endif

  // Handshakes: a Wishbone request (cyc & stb & address match) is taken only
  // while ack is low; ack then rises for exactly one cycle on the same edge that
  // commits the access, so a held strobe is served every other cycle. On the CPU
  // side a byte moves on any edge where valid and ready are both high; ready
  // never depends on valid.
  logic              wb_hit;
  logic              wb_req;
  logic              wb_wr;
  logic              wb_rd;
  logic [1:0]        reg_off;

  logic [CTRL_W-1:0] ctrl;
  logic              tx_ovf;
  logic              ctrl_wr;
  logic              tx_ovf_set;
  logic              tx_ovf_clr;
  logic              irq_next;
  logic [31:0]       rd_data;
  logic [31:0]       status_word;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [CW-1:0]     tx_count;

  logic              rx_push;
  logic              rx_pop;
  logic [7:0]        rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [CW-1:0]     rx_count;

  logic              unused_ok;

  assign wb_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wb_req  = wb_hit & ~wbs_ack_o;
  assign wb_wr   = wb_req & wbs_we_i;
  assign wb_rd   = wb_req & ~wbs_we_i;
  assign reg_off = wbs_adr_i[3:2];

  assign ctrl_wr    = wb_wr & (reg_off == REG_CTRL) & wbs_sel_i[0];
  assign tx_ovf_clr = wb_wr & (reg_off == REG_STATUS) & wbs_dat_i[ST_TX_OVF];

  assign tx_push    = wb_wr & (reg_off == REG_TXDATA) & wbs_sel_i[0];
  assign tx_pop     = tx_ready_i & tx_valid_o;
  // A full FIFO still takes the byte if the CPU drains one on the same edge.
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_pop  = wb_rd & (reg_off == REG_RXDATA) & ~rx_empty;

  assign cpu_rst_n_o = ctrl[CTRL_RUN];
  assign tx_valid_o  = ~tx_empty;
  assign rx_ready_o  = ~rx_full;

`ifdef AS2650_MBOX_TXIRQ_EN
  assign irq_next = (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) | (ctrl[CTRL_TX_IRQ_EN] & tx_empty);
`else
  assign irq_next = ctrl[CTRL_RX_IRQ_EN] & ~rx_empty;
`endif

  always_comb begin
    status_word                     = '0;
    status_word[ST_TX_FULL]         = tx_full;
    status_word[ST_TX_EMPTY]        = tx_empty;
    status_word[ST_RX_FULL]         = rx_full;
    status_word[ST_RX_EMPTY]        = rx_empty;
    status_word[ST_TX_OVF]          = tx_ovf;
    status_word[ST_TX_COUNT +: CW]  = tx_count;
    status_word[ST_RX_COUNT +: CW]  = rx_count;
  end

  always_comb begin
    rd_data = '0;
    case (reg_off)
      REG_CTRL:   rd_data = 32'(ctrl);
      REG_STATUS: rd_data = status_word;
      REG_TXDATA: rd_data = '0;
      REG_RXDATA: rd_data = rxdata_word(rx_empty, rx_head);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl      <= '0;
      tx_ovf    <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= wb_rd ? rd_data : '0;
      irq_o     <= irq_next;
      if (ctrl_wr) begin
        ctrl <= wbs_dat_i[CTRL_W-1:0];
      end
      if (tx_ovf_set) begin
        tx_ovf <= 1'b1;
      end else if (tx_ovf_clr) begin
        tx_ovf <= 1'b0;
      end
    end
  end

  mbox_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_tx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (tx_push),
    .push_data (wbs_dat_i[7:0]),
    .pop       (tx_pop),
    .head      (tx_data_o),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  mbox_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_rx_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (rx_push),
    .push_data (rx_data_i),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Byte-lane and address bits the register map never looks at.
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:8]};

endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Testbench for as2650_wb_mailbox: directed register-map checks plus randomized
// traffic compared cycle by cycle against a queue-based model of the mailbox.
module tb_as2650_wb_mailbox;
  import as2650_mbox_pkg::*;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;

`ifdef AS2650_MBOX_TXIRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cpu_rst_n_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  as2650_wb_mailbox #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .irq_o       (irq_o)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [2:0]  m_ctrl;
  logic        m_ovf;
  logic        m_ack;
  logic        m_irq;
  logic [31:0] m_dat;

  function automatic logic [31:0] exp_status();
    int s;
    s = 0;
    if (tx_q.size() == DEPTH) s += 1;
    if (tx_q.size() == 0)     s += 2;
    if (rx_q.size() == DEPTH) s += 4;
    if (rx_q.size() == 0)     s += 8;
    if (m_ovf)                s += 16;
    s += tx_q.size() * 256;
    s += rx_q.size() * 65536;
    return 32'(s);
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = 3'b0;
    m_ovf  = 1'b0;
    m_ack  = 1'b0;
    m_irq  = 1'b0;
    m_dat  = 32'h0;
  endtask

  task automatic model_step();
    logic        req;
    logic [1:0]  off;
    logic [31:0] nd;
    logic        nirq;
    logic        tx_was_full;
    logic        tx_pop;
    logic        rx_push;
    req = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
    off = wbs_adr_i[3:2];
    nd  = 32'h0;
    if (req && !wbs_we_i) begin
      if (off == 2'd0) nd = 32'(m_ctrl);
      if (off == 2'd1) nd = exp_status();
      if (off == 2'd3 && rx_q.size() != 0) nd = 32'h100 + 32'(rx_q[0]);
    end
    nirq = m_ctrl[1] && (rx_q.size() != 0);
`ifdef AS2650_MBOX_TXIRQ_EN
    nirq = nirq || (m_ctrl[2] && (tx_q.size() == 0));
`endif
    tx_was_full = (tx_q.size() == DEPTH);
    tx_pop      = tx_ready_i && (tx_q.size() != 0);
    rx_push     = rx_valid_i && (rx_q.size() < DEPTH);
    if (tx_pop) void'(tx_q.pop_front());
    if (req && wbs_we_i) begin
      if (off == 2'd0 && wbs_sel_i[0]) m_ctrl = wbs_dat_i[2:0] & CTRL_MASK;
      if (off == 2'd1 && wbs_dat_i[4]) m_ovf = 1'b0;
      if (off == 2'd2 && wbs_sel_i[0]) begin
        if (!tx_was_full || tx_pop) tx_q.push_back(wbs_dat_i[7:0]);
        else m_ovf = 1'b1;
      end
    end
    if (req && !wbs_we_i && off == 2'd3 && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rx_push) rx_q.push_back(rx_data_i);
    m_ack = req;
    m_dat = nd;
    m_irq = nirq;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Scoreboard: every output compared against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("mon_ack", 32'(wbs_ack_o), 32'(m_ack));
        check_eq("mon_dat", wbs_dat_o, m_dat);
        check_eq("mon_irq", 32'(irq_o), 32'(m_irq));
        check_eq("mon_cpu_rst_n", 32'(cpu_rst_n_o), 32'(m_ctrl[0]));
        check_eq("mon_tx_valid", 32'(tx_valid_o), 32'(tx_q.size() != 0));
        check_eq("mon_rx_ready", 32'(rx_ready_o), 32'(rx_q.size() < DEPTH));
        if (tx_q.size() != 0) check_eq("mon_tx_data", 32'(tx_data_o), 32'(tx_q[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output logic acked, output int lat);
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    rdat  = 32'h0;
    acked = 1'b0;
    lat   = 0;
    while (!acked && lat < 4) begin
      @(negedge clk);
      lat++;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic        ak;
    int          lt;
    wb_xfer(1'b1, BASE + {28'h0, off, 2'b00}, dat, sel, rd, ak, lt);
    check_eq("wr_ack_latency", 32'(lt), 32'd1);
  endtask

  task automatic wb_read(input logic [1:0] off, output logic [31:0] dat);
    logic ak;
    int   lt;
    wb_xfer(1'b0, BASE + {28'h0, off, 2'b00}, 32'h0, 4'hF, dat, ak, lt);
    check_eq("rd_ack_latency", 32'(lt), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] rdat;
  logic        acked;
  int          lat;
  int          n_acks;
  logic        rnd_done;
  logic [7:0]  tx_bytes[3];

  initial begin
    tx_bytes[0] = 8'h11;
    tx_bytes[1] = 8'h22;
    tx_bytes[2] = 8'h33;
    repeat (3) @(negedge clk);
    check_eq("reset_ack", 32'(wbs_ack_o), 32'd0);
    check_eq("reset_dat", wbs_dat_o, 32'h0);
    check_eq("reset_cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    check_eq("reset_tx_valid", 32'(tx_valid_o), 32'd0);
    check_eq("reset_rx_ready", 32'(rx_ready_o), 32'd1);
    check_eq("reset_irq", 32'(irq_o), 32'd0);
    rst_n = 1'b1;

    wb_read(REG_STATUS, rdat);
    check_eq("status_after_reset", rdat, 32'h0000_000A);

    wb_write(REG_CTRL, 32'h1, 4'hF);
    check_eq("cpu_released", 32'(cpu_rst_n_o), 32'd1);
    wb_write(REG_CTRL, 32'h0, 4'h0);
    check_eq("ctrl_sel0_ignored", 32'(cpu_rst_n_o), 32'd1);
    wb_read(REG_CTRL, rdat);
    check_eq("ctrl_readback", rdat, 32'h1);

    foreach (tx_bytes[i]) wb_write(REG_TXDATA, {24'h0, tx_bytes[i]}, 4'h1);
    wb_read(REG_TXDATA, rdat);
    check_eq("txdata_reads_zero", rdat, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("tx_order", 32'(tx_data_o), 32'(tx_bytes[i]));
      tx_ready_i = 1'b1;
      @(negedge clk);
      tx_ready_i = 1'b0;
    end
    check_eq("tx_drained", 32'(tx_valid_o), 32'd0);

    for (int i = 0; i < 9; i++) wb_write(REG_TXDATA, 32'($urandom_range(0, 255)), 4'hF);
    wb_read(REG_STATUS, rdat);
    check_eq("status_tx_overflow", rdat, 32'h0000_0819);
    wb_write(REG_STATUS, 32'h10, 4'hF);
    wb_read(REG_STATUS, rdat);
    check_eq("status_ovf_cleared", rdat, 32'h0000_0809);
    @(negedge clk);
    tx_ready_i = 1'b1;
    repeat (DEPTH) @(negedge clk);
    tx_ready_i = 1'b0;
    check_eq("tx_empty_again", 32'(tx_valid_o), 32'd0);

    wb_write(REG_CTRL, 32'h3, 4'hF);
    @(negedge clk);
    rx_data_i  = 8'hA5;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    check_eq("irq_latency_low", 32'(irq_o), 32'd0);
    @(negedge clk);
    check_eq("irq_raised", 32'(irq_o), 32'd1);
    wb_read(REG_RXDATA, rdat);
    check_eq("rxdata_value", rdat, 32'h0000_01A5);
    @(negedge clk);
    check_eq("irq_fell", 32'(irq_o), 32'd0);
    wb_read(REG_RXDATA, rdat);
    check_eq("rxdata_empty", rdat, 32'h0);

    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, rdat, acked, lat);
    check_eq("unmatched_no_ack", 32'(acked), 32'd0);

    // Held strobe: acks alternate, 3 in 6 cycles.
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = BASE + 32'h4;
    n_acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (wbs_ack_o) n_acks++;
    end
    check_eq("held_stb_acks", 32'(n_acks), 32'd3);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;

    // Reset during a held strobe, with data sitting in TX.
    wb_write(REG_TXDATA, 32'h5A, 4'h1);
    @(negedge clk);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_adr_i = BASE;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wbs_ack_o && lat < 4);
    check_eq("held_ack_seen", 32'(wbs_ack_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_reset_ack", 32'(wbs_ack_o), 32'd0);
    check_eq("mid_reset_tx_valid", 32'(tx_valid_o), 32'd0);
    check_eq("mid_reset_cpu_rst_n", 32'(cpu_rst_n_o), 32'd0);
    @(negedge clk);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(REG_STATUS, rdat);
    check_eq("status_after_mid_reset", rdat, 32'h0000_000A);

    // Randomized traffic against the model.
    rnd_done = 1'b0;
    fork
      begin
        int guard;
        guard = 0;
        while (!rnd_done && guard < 20000) begin
          @(negedge clk);
          guard++;
          tx_ready_i = ($urandom_range(0, 15) == 0);
          rx_valid_i = ($urandom_range(0, 1) == 1);
          rx_data_i  = 8'($urandom_range(0, 255));
        end
        tx_ready_i = 1'b0;
        rx_valid_i = 1'b0;
      end
      begin
        for (int k = 0; k < 400; k++) begin
          logic        we;
          logic        hit;
          logic [31:0] adr;
          we  = ($urandom_range(0, 1) == 1);
          hit = ($urandom_range(0, 9) != 0);
          adr = hit ? BASE + 32'($urandom_range(0, 3) * 4) : BASE + 32'h10 + 32'($urandom_range(0, 3) * 4);
          wb_xfer(we, adr, $urandom, 4'($urandom_range(0, 15)), rdat, acked, lat);
          check_eq("rnd_ack", 32'(acked), 32'(hit));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_done = 1'b1;
      end
    join

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
